// File: rtl/mm_rdr_pkg.sv
// Shared types and constants for the matrix_multiply result reader.
// Optional feature macro: MM_RDR_CHECKSUM_EN adds a trailing XOR checksum byte.
package mm_rdr_pkg;

    localparam int unsigned RESULT_W         = 17;
    localparam int unsigned NUM_RESULTS      = 4;
    localparam int unsigned BYTES_PER_RESULT = 3;
    localparam int unsigned WORD_W           = BYTES_PER_RESULT * 8;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StCapture,
        StSend,
`ifdef MM_RDR_CHECKSUM_EN
        StCsum,
`endif
        StFinish
    } rdr_state_e;

    // Pick byte 'idx' (0 = least significant) out of a captured word.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mm_rdr_byte_tx.sv
// Byte serializer: holds one captured result word and streams it out LSB first
// over a valid/ready handshake.
module mm_rdr_byte_tx
    import mm_rdr_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [RESULT_W-1:0] word_i,
    input  logic                out_ready_i,
    output logic [7:0]          out_data_o,
    output logic                out_valid_o,
    output logic                fire_o,
    output logic                last_o
);

    localparam logic [1:0] LastByte = 2'(BYTES_PER_RESULT - 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;

    assign fire_o      = valid_q & out_ready_i;
    assign last_o      = fire_o && (cnt_q == LastByte);
    // Data only moves on a transfer, so it is stable during stalls.
    assign out_data_o  = word_byte(word_q, cnt_q);
    assign out_valid_o = valid_q;

    // Next-state: load a new word, or advance the byte pointer on each transfer.
    always_comb begin
        word_d  = word_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = WORD_W'(word_i);
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (fire_o) begin
            if (cnt_q == LastByte) begin
                cnt_d   = '0;
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    // Capture register, byte counter and valid flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/mm_result_reader.sv
// Drains the four matrix_multiply results: selects each index, waits for the
// result to settle, captures it and streams it as three bytes.
// Optional feature macro: MM_RDR_CHECKSUM_EN appends an XOR-of-all-bytes byte.
module mm_result_reader
    import mm_rdr_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [RESULT_W-1:0] mm_out,
    output logic [1:0]          mm_sel_out,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LastIdx    = 2'(NUM_RESULTS - 1);
`ifdef MM_RDR_CHECKSUM_EN
    localparam rdr_state_e AfterLast  = StCsum;
`else
    localparam rdr_state_e AfterLast  = StFinish;
`endif

    rdr_state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;

    logic       tx_load;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_fire;
    logic       tx_last;

    mm_rdr_byte_tx u_byte_tx (
        .clk_i       (clk),
        .rst_i       (reset),
        .load_i      (tx_load),
        .word_i      (mm_out),
        .out_ready_i (out_ready),
        .out_data_o  (tx_data),
        .out_valid_o (tx_valid),
        .fire_o      (tx_fire),
        .last_o      (tx_last)
    );

    // Drain sequencing: settle, capture, send, then next index or finish.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        tx_load  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSelect;
                    idx_d    = '0;
                    settle_d = '0;
                end
            end
            StSelect: begin
                if (settle_q == SettleLast) begin
                    settle_d = '0;
                    state_d  = StCapture;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            StCapture: begin
                tx_load = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (tx_last) begin
                    if (idx_q == LastIdx) begin
                        state_d = AfterLast;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StSelect;
                    end
                end
            end
`ifdef MM_RDR_CHECKSUM_EN
            StCsum: begin
                if (out_ready) begin
                    state_d = StFinish;
                end
            end
`endif
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, result index and settle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
        end
    end

`ifdef MM_RDR_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running XOR over every data byte that actually transfers.
    always_comb begin
        csum_d = csum_q;
        if (state_q == StIdle && start) begin
            csum_d = '0;
        end else if (tx_fire) begin
            csum_d = csum_q ^ tx_data;
        end
    end

    // Checksum accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    // The byte transmitter is idle in StCsum, so the checksum owns the stream.
    assign out_valid = tx_valid | (state_q == StCsum);
    assign out_data  = (state_q == StCsum) ? csum_q : tx_data;
`else
    assign out_valid = tx_valid;
    assign out_data  = tx_data;
`endif

    assign mm_sel_out = idx_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFinish);

endmodule

// File: tb/tb_mm_result_reader.sv
// Self-checking bench for mm_result_reader: three instances (SETTLE_CYCLES 2, 1, 15)
// share the stimulus; a reference model predicts the byte stream per drain.
module tb_mm_result_reader;

`ifdef MM_RDR_CHECKSUM_EN
    localparam int NB = 13;
    localparam int CS = 1;
`else
    localparam int NB = 12;
    localparam int CS = 0;
`endif
    localparam int NI     = 3;
    localparam int NT     = 7;
    localparam int BUDGET = 800;
    localparam int MAXB   = 1024;

    typedef struct packed {
        logic [3:0][16:0] r;
        bit               rnd;
        int               restart_at;
        logic [12:0][7:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        out_ready = 1'b1;
    bit          rnd = 1'b0;
    logic [16:0] res[4];

    logic [16:0] mm_out[NI];
    logic [1:0]  sel[NI];
    logic [7:0]  dat[NI];
    logic        vld[NI];
    logic        busy_w[NI];
    logic        done_w[NI];

    int checks = 0;
    int failures = 0;

    // Monitor-owned state.
    int cyc = 0;
    int rel;
    int seen[NI], first_v[NI], got_n[NI], done_cnt[NI], done_c[NI], last_x[NI];
    int busy_last[NI], stall_bad[NI], stall_seen[NI], sel_bad[NI], held[NI];
    logic [1:0] psel[NI];
    logic       pv[NI];
    logic [7:0] pd[NI];
    logic       pr;
    logic [7:0] got[NI][MAXB];

    // Main-owned state.
    int   t0 = 0;
    int   run_id = 0;
    int   base_n[NI];
    vec_t tbl[NT];

    always #5 clk = ~clk;

    function automatic int settle_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 15;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        mm_result_reader #(.SETTLE_CYCLES(S)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .mm_out     (mm_out[g]),
            .mm_sel_out (sel[g]),
            .out_data   (dat[g]),
            .out_valid  (vld[g]),
            .out_ready  (out_ready),
            .busy       (busy_w[g]),
            .done       (done_w[g])
        );
        // Result is only trustworthy once the index has been held for S cycles.
        assign mm_out[g] = (held[g] >= S && sel[g] == psel[g]) ? res[sel[g]] : ~res[sel[g]];
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Reference model: each result as plain integer bytes, LSB first, plus XOR.
    function automatic vec_t mk(input logic [16:0] a, input logic [16:0] b, input logic [16:0] c,
                                input logic [16:0] d, input bit rn, input int rs);
        vec_t v;
        logic [7:0] x;
        int val;
        v = '0;
        v.r[0] = a;
        v.r[1] = b;
        v.r[2] = c;
        v.r[3] = d;
        v.rnd = rn;
        v.restart_at = rs;
        x = 8'h00;
        for (int w = 0; w < 4; w++) begin
            val = int'(v.r[w]);
            for (int k = 0; k < 3; k++) begin
                v.exp[w*3+k] = 8'((val >> (8 * k)) & 255);
                x = x ^ v.exp[w*3+k];
            end
        end
        v.exp[12] = x;
        return v;
    endfunction

    function automatic logic [16:0] r17();
        return 17'($urandom_range(0, 32'h1FFFF));
    endfunction

    // Backpressure driver.
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor: records transfers, done/busy timing and handshake violations.
    initial begin : mon
        pr = 1'b1;
        for (int i = 0; i < NI; i++) begin
            seen[i] = 0; first_v[i] = -1; got_n[i] = 0; done_cnt[i] = 0; done_c[i] = -1;
            last_x[i] = -1; busy_last[i] = -1; stall_bad[i] = 0; stall_seen[i] = 0;
            sel_bad[i] = 0; held[i] = 100; psel[i] = 2'd0; pv[i] = 1'b0; pd[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            cyc++;
            rel = cyc - t0;
            for (int i = 0; i < NI; i++) begin
                if (pv[i] && !pr) begin
                    stall_seen[i]++;
                    if (!(vld[i] && dat[i] == pd[i])) stall_bad[i]++;
                end
                if (vld[i] && seen[i] != run_id) begin
                    seen[i] = run_id;
                    first_v[i] = rel;
                end
                if (vld[i] && (got_n[i] - base_n[i]) < 12 &&
                    sel[i] != 2'((got_n[i] - base_n[i]) / 3)) sel_bad[i]++;
                if (vld[i] && out_ready) begin
                    if (got_n[i] < MAXB) got[i][got_n[i]] = dat[i];
                    got_n[i]++;
                    last_x[i] = rel;
                end
                if (done_w[i]) begin
                    done_cnt[i]++;
                    done_c[i] = rel;
                end
                if (busy_w[i]) busy_last[i] = rel;
                if (sel[i] != psel[i]) held[i] = 0;
                else if (held[i] < 1000) held[i]++;
                psel[i] = sel[i];
                pv[i] = vld[i];
                pd[i] = dat[i];
            end
            pr = out_ready;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic run_drain(input int k);
        bit all_done;
        int bd[NI];
        int s, nb, fv;
        for (int j = 0; j < 4; j++) res[j] = tbl[k].r[j];
        rnd = tbl[k].rnd;
        run_id++;
        for (int i = 0; i < NI; i++) begin
            base_n[i] = got_n[i];
            bd[i] = done_cnt[i];
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc + 1;
        all_done = 1'b0;
        for (int n = 0; n < BUDGET && !all_done; n++) begin
            @(posedge clk);
            #1;
            start = (tbl[k].restart_at != 0) && (cyc + 1 - t0 == tbl[k].restart_at);
            all_done = 1'b1;
            for (int i = 0; i < NI; i++) if (done_cnt[i] == bd[i]) all_done = 1'b0;
        end
        start = 1'b0;
        check(all_done, $sformatf("drain_timeout case=%0d", k), int'(all_done), 1);
        repeat (30) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            s = settle_of(i);
            nb = got_n[i] - base_n[i];
            check(nb == NB, $sformatf("byte_count case=%0d inst=%0d", k, i), nb, NB);
            for (int b = 0; b < NB && b < nb; b++) begin
                if (base_n[i] + b < MAXB)
                    check(got[i][base_n[i]+b] == tbl[k].exp[b],
                          $sformatf("byte case=%0d inst=%0d idx=%0d", k, i, b),
                          int'(got[i][base_n[i]+b]), int'(tbl[k].exp[b]));
            end
            fv = (seen[i] == run_id) ? first_v[i] : -1;
            check(fv == s + 2, $sformatf("first_valid case=%0d inst=%0d", k, i), fv, s + 2);
            check(done_cnt[i] - bd[i] == 1, $sformatf("done_count case=%0d inst=%0d", k, i),
                  done_cnt[i] - bd[i], 1);
            check(last_x[i] == done_c[i] - 1, $sformatf("done_after_last case=%0d inst=%0d", k, i),
                  done_c[i], last_x[i] + 1);
            check(busy_last[i] == done_c[i], $sformatf("busy_end case=%0d inst=%0d", k, i),
                  busy_last[i], done_c[i]);
            check(stall_bad[i] == 0, $sformatf("stall_hold case=%0d inst=%0d", k, i),
                  stall_bad[i], 0);
            check(sel_bad[i] == 0, $sformatf("sel_stable case=%0d inst=%0d", k, i), sel_bad[i], 0);
            if (!tbl[k].rnd)
                check(done_c[i] == 4 * (s + 4) + CS + 1,
                      $sformatf("done_cycle case=%0d inst=%0d", k, i), done_c[i],
                      4 * (s + 4) + CS + 1);
        end
    endtask

    // Hand-derived byte stream for results {19,22,43,50} on the default instance.
    task automatic lit_check_basic();
        logic [7:0] lit[12];
        lit = '{8'h13, 8'h00, 8'h00, 8'h16, 8'h00, 8'h00,
                8'h2B, 8'h00, 8'h00, 8'h32, 8'h00, 8'h00};
        for (int b = 0; b < 12; b++)
            check(got[0][base_n[0]+b] == lit[b], $sformatf("literal_byte idx=%0d", b),
                  int'(got[0][base_n[0]+b]), int'(lit[b]));
`ifdef MM_RDR_CHECKSUM_EN
        check(got[0][base_n[0]+12] == 8'h1C, "literal_csum", int'(got[0][base_n[0]+12]), 'h1C);
`endif
    endtask

    initial begin : main
        int rd[NI];
        reset = 1'b1;
        start = 1'b0;
        for (int j = 0; j < 4; j++) res[j] = 17'h0;
        for (int i = 0; i < NI; i++) base_n[i] = 0;

        tbl[0] = mk(17'd19, 17'd22, 17'd43, 17'd50, 1'b0, 0);
        tbl[1] = mk(17'h000AA, 17'h10000, 17'd130050, 17'h1FFFF, 1'b0, 0);
        tbl[2] = mk(17'd19, 17'd22, 17'd43, 17'd50, 1'b1, 0);
        tbl[3] = mk(r17(), r17(), r17(), r17(), 1'b1, 0);
        tbl[4] = mk(17'd7, 17'd8, 17'd9, 17'd10, 1'b0, 5);
        tbl[5] = mk(r17(), r17(), r17(), r17(), 1'b1, 15);
        tbl[6] = mk(r17(), r17(), r17(), r17(), 1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check({vld[i], busy_w[i], done_w[i], sel[i], dat[i]} == 13'd0,
                  $sformatf("reset_state inst=%0d", i),
                  int'({vld[i], busy_w[i], done_w[i], sel[i], dat[i]}), 0);

        for (int k = 0; k < NT; k++) begin
            run_drain(k);
            if (k == 0) lit_check_basic();
            if (k == 1) begin
                check(got[0][base_n[0]+6] == 8'h02, "max_b0", int'(got[0][base_n[0]+6]), 'h02);
                check(got[0][base_n[0]+7] == 8'hFC, "max_b1", int'(got[0][base_n[0]+7]), 'hFC);
                check(got[0][base_n[0]+8] == 8'h01, "max_b2", int'(got[0][base_n[0]+8]), 'h01);
            end
        end

        // Reset in the middle of word 1's SEND on the default instance.
        for (int j = 0; j < 4; j++) res[j] = tbl[0].r[j];
        rnd = 1'b0;
        run_id++;
        for (int i = 0; i < NI; i++) begin
            base_n[i] = got_n[i];
            rd[i] = done_cnt[i];
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc + 1 - t0 < 11) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check(sel[0] == 2'd1 && vld[0], "pre_reset_send_w1", int'({sel[0], vld[0]}), 3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check({vld[i], busy_w[i], done_w[i], sel[i]} == 5'd0,
                  $sformatf("post_reset inst=%0d", i),
                  int'({vld[i], busy_w[i], done_w[i], sel[i]}), 0);
        repeat (40) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            check(done_cnt[i] == rd[i], $sformatf("no_done_after_reset inst=%0d", i),
                  done_cnt[i] - rd[i], 0);

        // Start coincident with reset: reset wins.
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check(!busy_w[i], $sformatf("start_with_reset inst=%0d", i), int'(busy_w[i]), 0);

        // Fresh drain after reset must be complete and correct.
        run_drain(0);
        lit_check_basic();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
